// File: rtl/timer_pkg.sv
// Shared FSM state encoding for the timer sequencer and anything that observes it.
package timer_pkg;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;
endpackage

// File: rtl/timer_count_core.sv
// Loadable up/down counter; priority clr > load > en; updates one cycle after a control.
// No backpressure: controls are acted on every clock edge.
module timer_count_core #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + 1'b1 : count - 1'b1;
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Prescaled one-shot/periodic up/down timer; start at n -> busy at n+1, loaded count at n+2.
// No backpressure: done_tick is a single-cycle pulse, pause freezes time, stop aborts.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int W  = 16,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          pause,
    input  logic          periodic,
    input  logic          up,
    input  logic [W-1:0]  period,
    input  logic [PW-1:0] prescale,
    output logic          busy,
    output logic          done_tick,
    output logic [W-1:0]  count
);

    state_t        state, state_nxt;

    logic          periodic_q;
    logic          up_q;
    logic [W-1:0]  period_q;
    logic [PW-1:0] prescale_q;
    logic          load_cfg;

    logic [PW-1:0] presc, presc_nxt;
    logic          tick;
    logic          at_term;
    logic [W-1:0]  term_val;
    logic [W-1:0]  start_val;

    logic          cnt_clr;
    logic          cnt_load;
    logic          cnt_en;

    // Configuration snapshot taken on an accepted start; later input changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            periodic_q <= 1'b0;
            up_q       <= 1'b0;
            period_q   <= '0;
            prescale_q <= '0;
        end else if (load_cfg) begin
            periodic_q <= periodic;
            up_q       <= up;
            period_q   <= period;
            prescale_q <= prescale;
        end
    end

    assign term_val  = up_q ? period_q : '0;
    assign start_val = up_q ? '0 : period_q;
    assign at_term   = (count == term_val);
    assign tick      = (state == RUN) && !pause && (presc == prescale_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else begin
            presc <= presc_nxt;
        end
    end

    // Pause holds the phase so a resumed interval loses no cycles.
    always_comb begin
        presc_nxt = presc;
        if (state == LOAD || stop) begin
            presc_nxt = '0;
        end else if (state == RUN && !pause) begin
            presc_nxt = (presc == prescale_q) ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_cfg  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        done_tick = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    load_cfg  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (stop) begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_load  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (stop) begin
                    cnt_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (at_term) begin
                        done_tick = 1'b1;
                        if (periodic_q) begin
                            cnt_load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    timer_count_core #(
        .W (W)
    ) u_count (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .en       (cnt_en),
        .up       (up_q),
        .load_val (start_val),
        .count    (count)
    );

endmodule

// File: tb/tb_timer_sequencer.sv
// Scoreboard bench: an arithmetic reference model predicts every cycle's outputs.
module tb_timer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, pause, periodic, up;
    logic [15:0] period;
    logic [7:0]  prescale;
    logic        busy, done_tick;
    logic [15:0] count;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    typedef struct {
        logic        busy;
        logic        done;
        logic [15:0] count;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   done_log[$];

    // Reference model: elapsed unpaused RUN cycles determine everything.
    typedef enum {M_IDLE, M_LOAD, M_RUN} mmode_t;
    mmode_t m_mode;
    int     m_hold, m_p;
    bit     c_periodic, c_up;
    int     c_per, c_ps;

    timer_sequencer #(.W(16), .PW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .periodic  (periodic),
        .up        (up),
        .period    (period),
        .prescale  (prescale),
        .busy      (busy),
        .done_tick (done_tick),
        .count     (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: compare whatever the DUT presents against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_tick === 1'b1) done_log.push_back(cycle);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (busy !== e.busy || done_tick !== e.done || count !== e.count) begin
                    fails++;
                    $display("FAIL cycle_%0d busy/done/count got %b/%b/%0d want %b/%b/%0d",
                             e.cyc, busy, done_tick, count, e.busy, e.done, e.count);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_hold = 0; m_p = 0;
        c_periodic = 0; c_up = 0; c_per = 0; c_ps = 0;
    endtask

    // Drive one cycle of inputs, predict outputs, advance the model past the edge.
    task automatic cyc(input bit s, input bit st, input bit pa, input bit pe, input bit u,
                       input int per, input int ps);
        exp_t   e;
        mmode_t n_mode = m_mode;
        int     n_hold = m_hold;
        int     n_p    = m_p;
        int     tidx, phase, step, cnt;
        bit     tk, dn;
        start = s; stop = st; pause = pa; periodic = pe; up = u;
        period = per[15:0]; prescale = ps[7:0];
        e.cyc = cycle; e.busy = 0; e.done = 0; e.count = m_hold[15:0];
        case (m_mode)
            M_IDLE: begin
                if (s && !st) begin
                    c_periodic = pe; c_up = u; c_per = per; c_ps = ps;
                    n_mode = M_LOAD;
                end
            end
            M_LOAD: begin
                e.busy = 1;
                if (st) begin n_hold = 0; n_mode = M_IDLE; end
                else begin n_mode = M_RUN; n_p = 0; end
            end
            M_RUN: begin
                tidx  = m_p / (c_ps + 1);
                phase = m_p % (c_ps + 1);
                step  = tidx % (c_per + 1);
                cnt   = c_up ? step : c_per - step;
                tk    = !pa && (phase == c_ps);
                dn    = tk && (step == c_per) && !st;
                e.busy = 1; e.done = dn; e.count = cnt[15:0];
                if (st) begin
                    n_hold = 0; n_mode = M_IDLE;
                end else if (!pa) begin
                    if (dn && !c_periodic) begin n_hold = cnt; n_mode = M_IDLE; end
                    else if (dn) n_p = 0;
                    else n_p = m_p + 1;
                end
            end
            default: ;
        endcase
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        m_mode = n_mode; m_hold = n_hold; m_p = n_p;
    endtask

    // Quiet cycles with scrambled configuration inputs, which must have no effect.
    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            cyc(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 9), $urandom_range(0, 5));
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        chk("async_reset_busy", busy, 0);
        chk("async_reset_done", done_tick, 0);
        chk("async_reset_count", count, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic run_oneshot3(input string name);
        int n;
        done_log.delete();
        n = cycle;
        cyc(1, 0, 0, 0, 1, 3, 0);
        idle(6);
        chk({name, "_ndone"}, done_log.size(), 1);
        chk({name, "_done_at"}, done_log[0] - n, 5);
        chk({name, "_final_count"}, count, 3);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 0; stop = 0; pause = 0; periodic = 0; up = 0;
        period = '0; prescale = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done_tick, 0);
        chk("reset_count", count, 0);
        reset = 1'b0;

        run_oneshot3("oneshot_up");

        // Periodic down count with prescale 1.
        done_log.delete();
        n = cycle;
        cyc(1, 0, 0, 1, 0, 2, 1);
        idle(19);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("periodic_ndone", done_log.size(), 3);
        chk("periodic_first", done_log[0] - n, 7);
        chk("periodic_gap1", done_log[1] - done_log[0], 6);
        chk("periodic_gap2", done_log[2] - done_log[1], 6);

        // Pause for 5 cycles mid-interval shifts done by 5 (n+13 -> n+18).
        done_log.delete();
        n = cycle;
        cyc(1, 0, 0, 0, 1, 2, 3);
        idle(4);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0, 7, 0);
        idle(12);
        chk("pause_ndone", done_log.size(), 1);
        chk("pause_done_at", done_log[0] - n, 18);

        // Stop coinciding with the terminal tick.
        done_log.delete();
        cyc(1, 0, 0, 0, 1, 1, 0);
        idle(2);
        cyc(0, 1, 0, 0, 1, 1, 0);
        chk("stop_term_ndone", done_log.size(), 0);
        chk("stop_term_count", count, 0);
        chk("stop_term_busy", busy, 0);

        // Period 0 periodic: done on every RUN cycle.
        done_log.delete();
        cyc(1, 0, 0, 1, 1, 0, 0);
        idle(9);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("period0_ndone", done_log.size(), 8);

        // start with stop in IDLE stays idle.
        cyc(1, 1, 0, 1, 1, 4, 0);
        idle(3);
        chk("start_stop_busy", busy, 0);

        // Asynchronous reset mid-run, then a fresh run.
        cyc(1, 0, 0, 1, 0, 6, 2);
        idle(5);
        async_reset();
        run_oneshot3("after_reset");

        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) async_reset();
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 6), $urandom_range(0, 3));
        end
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Parameters
REQ-001 W, default 16, width of the count and period datapath.
REQ-002 PW, default 8, width of the prescaler.

Interface
REQ-003 clk  in  1  system clock, rising-edge active.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  single-cycle request to start a timing run; sampled only in IDLE.
REQ-006 stop  in  1  abort; honoured in any non-IDLE state.
REQ-007 pause  in  1  level input; while high in RUN, ticks are suppressed.
REQ-008 periodic  in  1  1 = auto-reload at terminal count, 0 = one-shot; latched at start.
REQ-009 up  in  1  1 = count 0 up to period, 0 = count period down to 0; latched at start.
REQ-010 period  in  W  terminal/reload value; latched at start.
REQ-011 prescale  in  PW  tick every prescale+1 clk cycles; latched at start.
REQ-012 busy  out  1  high in LOAD and RUN.
REQ-013 done_tick  out  1  one-cycle pulse at each terminal event.
REQ-014 count  out  W  current counter value.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD and RUN.
REQ-016 IDLE with start=1 SHALL latch periodic, up, period and prescale, then go to LOAD.
REQ-017 LOAD SHALL, for one cycle, load count (0 if up, period if down), clear the prescaler, then go to RUN.
REQ-018 Latency SHALL be fixed: start at cycle n gives busy=1 from n+1 and the loaded count visible at n+2.
REQ-019 In RUN with pause=0, the prescaler SHALL count 0..prescale and assert an internal tick when it wraps; prescale=0 gives a tick every cycle.
REQ-020 pause=1 SHALL freeze the prescaler and count; release resumes without loss of prescaler phase.
REQ-021 On a tick where count differs from the terminal value (period if up, 0 if down), count SHALL step by +1 or -1 (modulo 2^W never reached by construction).
REQ-022 On a tick where count equals the terminal value, done_tick SHALL assert for that cycle and the counter SHALL NOT step.
REQ-023 At that terminal tick, periodic=1 SHALL reload the start value and stay in RUN; periodic=0 SHALL go to IDLE holding count.
REQ-024 One run period SHALL therefore be (period+1)*(prescale+1) clk cycles; period=0 SHALL give done_tick on every tick.
REQ-025 stop SHALL take priority over tick and pause: next state IDLE, count cleared to 0, no done_tick.
REQ-026 start outside IDLE SHALL be ignored; start and stop together in IDLE SHALL leave the block in IDLE.
REQ-027 Changes to the latched inputs after start SHALL have no effect until the next start.

Reset
REQ-028 reset SHALL force state IDLE, count=0, prescaler=0, latched configuration=0, busy=0 and done_tick=0, including mid-run.
REQ-029 The first start after reset release SHALL behave exactly as REQ-016 to REQ-018.

Structure
REQ-030 The FSM state enum and the state-width constant SHALL live in a shared package, timer_pkg.
REQ-031 The count register SHALL be one sub-module, timer_count_core: a loadable up/down counter with sync clear, load, enable and direction inputs; the sequencer only drives its controls.
REQ-032 The prescaler and FSM SHALL be separate always_ff/always_comb pairs in timer_sequencer.

Verification
REQ-033 up=1, periodic=0, period=3, prescale=0, start: count 0,1,2,3 on cycles n+2..n+5; done_tick at n+5; IDLE at n+6 with count=3.
REQ-034 up=0, periodic=1, period=2, prescale=1: count 2,2,1,1,0,0; done_tick every 6 cycles; reload to 2; busy stays 1.
REQ-035 Run with prescale=3 and pause held for 5 cycles mid-interval: done_tick delayed by exactly 5 cycles.
REQ-036 stop asserted together with a terminal tick: no done_tick, count=0, IDLE next cycle.
REQ-037 period=0, periodic=1, prescale=0: done_tick every RUN cycle, count stays 0.
REQ-038 reset asserted asynchronously mid-RUN: outputs 0 immediately; a new start after release gives the REQ-033 sequence.
